// File: rtl/sr_nor_latch.sv
// sr_nor_latch -- one bit of storage behaving as a cross-coupled NOR SR pair.
//
// Ports:
//   S : set input, active-high
//   R : reset input, active-high
//   Q : stored value
//   P : complement of the stored value
//
// The NOR pair is written as a single level-sensitive storage node rather
// than two gates feeding each other. This keeps the model free of a
// zero-delay combinational loop that a cycle-based simulator cannot settle
// from an all-zero start. The visible behaviour is the same in every state
// the pair can settle into:
//   S=1, R=0 -> Q=1, P=0
//   S=0, R=1 -> Q=0, P=1
//   S=0, R=0 -> hold
// The S=1, R=1 case, where a real NOR pair drives both outputs low, cannot
// be produced by d_latch's input gating. Deriving P from the stored node
// means Q and P are always complementary.
module sr_nor_latch (
  input  logic S,
  input  logic R,
  output logic Q,
  output logic P
);

  logic state;

  // Open while either input is asserted. With S and R both low the node
  // keeps its last value, which is the hold state of the pair.
  always_latch begin
    if (S | R) begin
      state <= S;
    end
  end

  assign Q = state;
  assign P = ~state;

endmodule

// File: rtl/d_latch.sv
// d_latch -- WIDTH-bit level-sensitive gated D latch with synchronous reset.
//
// Ports:
//   CLK : clock, used only to sample RST
//   RST : reset, synchronous and active-high
//   D   : latch data, WIDTH bits
//   E   : gate enable, active-high (1 = transparent)
//   Q   : latched data, WIDTH bits
//   P   : complement of Q, WIDTH bits
//
// Each bit is one sr_nor_latch. Its set input is E & D and its reset input is
// E & ~D, so S and R are never both high. While the registered reset flag is
// high, every bit is driven with S=0 and R=1. The data path contains no clock,
// so a change on D while E=1 reaches Q in the same time step.
module d_latch #(
  parameter int WIDTH = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] D,
  input  logic             E,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] P
);

  localparam logic [WIDTH-1:0] ALL_ZEROS = '0;
  localparam logic [WIDTH-1:0] ALL_ONES  = '1;

  logic             rst_q;
  logic [WIDTH-1:0] set_in;
  logic [WIDTH-1:0] reset_in;
  logic [WIDTH-1:0] enable_vec;

  // Reset is seen only on a rising CLK edge. A reset raised while the latch
  // is transparent takes effect on the next edge. When the flag clears, the
  // gating below returns to normal operation at once.
  always_ff @(posedge CLK) begin
    rst_q <= RST;
  end

  assign enable_vec = {WIDTH{E}};

  // The reset override takes priority over E and D. Forcing R=1 clears every
  // bit, so Q=0 and P=all ones for as long as rst_q stays high.
  always_comb begin
    set_in   = enable_vec & D;
    reset_in = enable_vec & ~D;
    if (rst_q) begin
      set_in   = ALL_ZEROS;
      reset_in = ALL_ONES;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sr_nor_latch u_sr (
      .S (set_in[i]),
      .R (reset_in[i]),
      .Q (Q[i]),
      .P (P[i])
    );
  end

endmodule

// File: tb/tb_d_latch.sv
// tb_d_latch -- directed, self-checking bench for d_latch.
// Two instances are used: WIDTH=1 for the single-bit scenarios and WIDTH=8
// for the multi-bit hold scenario. Both share CLK and RST.
module tb_d_latch;

  logic       clk;
  logic       rst;
  logic       d1;
  logic       e1;
  logic       q1;
  logic       p1;
  logic [7:0] d8;
  logic       e8;
  logic [7:0] q8;
  logic [7:0] p8;

  int testCount;
  int failCount;

  d_latch #(.WIDTH(1)) u_dut1 (
    .CLK (clk),
    .RST (rst),
    .D   (d1),
    .E   (e1),
    .Q   (q1),
    .P   (p1)
  );

  d_latch #(.WIDTH(8)) u_dut8 (
    .CLK (clk),
    .RST (rst),
    .D   (d8),
    .E   (e8),
    .Q   (q8),
    .P   (p8)
  );

  // Rising edges fall at 10, 30, 50 ns, and so on.
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Compares one observed value against its expected value and counts it.
  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    testCount++;
    assert (observed === expected)
      else begin
        failCount++;
        $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
  endtask

  // Checks Q and P of the 1-bit instance. P must always be the complement of Q.
  task automatic check1(input string tag, input logic expQ);
    checkOutput({tag, ".Q"}, {7'b0, q1}, {7'b0, expQ});
    checkOutput({tag, ".P"}, {7'b0, p1}, {7'b0, ~expQ});
    checkOutput({tag, ".QneP"}, {7'b0, p1 ^ q1}, 8'h01);
  endtask

  // Checks Q and P of the 8-bit instance. P must always be the complement of Q.
  task automatic check8(input string tag, input logic [7:0] expQ);
    checkOutput({tag, ".Q"}, q8, expQ);
    checkOutput({tag, ".P"}, p8, ~expQ);
    checkOutput({tag, ".QneP"}, p8 ^ q8, 8'hFF);
  endtask

  // Drives every data input in one step, so D and E change together.
  task automatic applyStimulus(input logic nd1, input logic ne1,
                               input logic [7:0] nd8, input logic ne8);
    d1 = nd1;
    e1 = ne1;
    d8 = nd8;
    e8 = ne8;
  endtask

  initial begin
    testCount = 0;
    failCount = 0;
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);

    // Q is not checked before the first reset.
    @(negedge clk);
    @(negedge clk);
    #1 check1("reset_w1", 1'b0);
    check8("reset_w8", 8'h00);

    // Release reset. After release with E=0, Q holds 0.
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1 check1("post_release_hold", 1'b0);

    // With E=0, Q stays 0 for D=0 and for D=1.
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    #1 check1("e0_d0_start", 1'b0);
    #99 check1("e0_d0_end", 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    #1 check1("e0_d1_start", 1'b0);
    #99 check1("e0_d1_end", 1'b0);

    // Transparent: Q follows D without a clock edge.
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
    #1 check1("e1_d0_start", 1'b0);
    #99 check1("e1_d0_end", 1'b0);
    applyStimulus(1'b1, 1'b1, 8'h00, 1'b0);
    #0 check1("e1_d1_same_step", 1'b1);
    #1 check1("e1_d1_start", 1'b1);
    #99 check1("e1_d1_end", 1'b1);

    // Drop E with D=1, then toggle D. Q must stay 1.
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    #1 check1("hold_after_fall", 1'b1);
    for (int i = 0; i < 4; i++) begin
      #19 d1 = ~d1;
      #1 check1("hold_toggle", 1'b1);
    end

    // D and E change together: new E=1 takes the new D.
    #19 applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
    #1 check1("simul_e1_d0", 1'b0);
    // New E=0 keeps the previous value (0) and ignores the new D=1.
    #19 applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    #1 check1("simul_e0_d1", 1'b0);

    // Reset while transparent with Q=1. It acts only at the next rising edge.
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 8'h00, 1'b0);
    #1 check1("pre_rst_q1", 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1 check1("rst_before_edge", 1'b1);
    @(posedge clk);
    #1 check1("rst_after_edge", 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1 check1("rst_flag_still_set", 1'b0);
    d1 = 1'b0;
    #1 check1("rst_overrides_d", 1'b0);
    d1 = 1'b1;
    @(posedge clk);
    #1 check1("rst_release_follow", 1'b1);

    // 8-bit: capture A5, drop E, then change D. Q holds A5 and P is 5A.
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 8'hA5, 1'b1);
    #1 check8("w8_transparent", 8'hA5);
    applyStimulus(1'b1, 1'b1, 8'hA5, 1'b0);
    #1 applyStimulus(1'b1, 1'b1, 8'h3C, 1'b0);
    #1 check8("w8_hold", 8'hA5);
    #18 applyStimulus(1'b1, 1'b1, 8'h3C, 1'b1);
    #1 check8("w8_reopen", 8'h3C);
    // D and E change together: E falls while D changes, so Q keeps 3C.
    #19 applyStimulus(1'b1, 1'b1, 8'hFF, 1'b0);
    #1 check8("w8_simul_close", 8'h3C);
    // E rises while D changes, so Q takes the new D.
    #19 applyStimulus(1'b1, 1'b1, 8'h0F, 1'b1);
    #1 check8("w8_simul_open", 8'h0F);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
